// File: rtl/risc16b_mem_arbiter.sv
// Single-port memory arbiter for the risc16b core: shares one synchronous memory
// between fetch and data ports, splits the I/O page onto its own bus.
module risc16b_mem_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter logic [7:0]  IO_PAGE      = 8'h7f
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_req_i,
  input  logic [15:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [15:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic [15:0] d_addr_i,
  input  logic [1:0]  d_we_i,
  input  logic [15:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [15:0] d_rdata_o,
  output logic [15:0] m_addr_o,
  output logic        m_oe_o,
  output logic [1:0]  m_we_o,
  output logic [15:0] m_wdata_o,
  input  logic [15:0] m_rdata_i,
  output logic [7:0]  io_addr_o,
  output logic        io_oe_o,
  output logic [1:0]  io_we_o,
  output logic [15:0] io_wdata_o,
  input  logic [15:0] io_rdata_i
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_src_i_q, rd_src_i_d;
  logic        rd_io_q, rd_io_d;

  logic        arb_i_s, arb_d_s;
  logic [15:0] sel_addr_s;
  logic        is_io_s, is_rd_s;
  logic [1:0]  we_s;
  logic [15:0] rdata_s;

  // Arbitration: d wins ties until the fetch port has waited STARVE_LIMIT grants.
  always_comb begin
    arb_i_s = 1'b0;
    arb_d_s = 1'b0;
    if (i_req_i && (!d_req_i || (starve_q == LIMIT_C))) begin
      arb_i_s = 1'b1;
    end else if (d_req_i) begin
      arb_d_s = 1'b1;
    end else begin
      arb_d_s = 1'b0;
    end
  end

  // Starvation counter next state, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!i_req_i || arb_i_s) begin
      starve_d = 4'd0;
    end else if (arb_d_s && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Command decode; unused address/wdata follow the d port when idle.
  always_comb begin
    sel_addr_s = arb_i_s ? i_addr_i : d_addr_i;
    is_io_s    = (sel_addr_s[15:8] == IO_PAGE);
    is_rd_s    = arb_i_s | (arb_d_s & (d_we_i == 2'b00));
    we_s       = arb_d_s ? d_we_i : 2'b00;
  end

  // Reset gates every strobe combinationally so it takes effect before any edge.
  always_comb begin
    i_gnt_o    = rst_ni & arb_i_s;
    d_gnt_o    = rst_ni & arb_d_s;
    m_addr_o   = sel_addr_s;
    m_wdata_o  = d_wdata_i;
    io_addr_o  = sel_addr_s[7:0];
    io_wdata_o = d_wdata_i;
    m_oe_o     = rst_ni & is_rd_s & ~is_io_s;
    io_oe_o    = rst_ni & is_rd_s & is_io_s;
    m_we_o     = 2'b00;
    io_we_o    = 2'b00;
    if (rst_ni && is_io_s) begin
      io_we_o = we_s;
    end else if (rst_ni) begin
      m_we_o = we_s;
    end else begin
      m_we_o = 2'b00;
    end
  end

  // Outstanding-read tracker next state: one read in flight at most per cycle.
  always_comb begin
    rd_pend_d  = is_rd_s;
    rd_src_i_d = arb_i_s;
    rd_io_d    = is_io_s;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q   <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_src_i_q <= 1'b0;
      rd_io_q    <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      rd_src_i_q <= rd_src_i_d;
      rd_io_q    <= rd_io_d;
    end
  end

  // Read return steering; the idle port always sees zero data.
  always_comb begin
    rdata_s    = rd_io_q ? io_rdata_i : m_rdata_i;
    i_rvalid_o = rd_pend_q & rd_src_i_q;
    d_rvalid_o = rd_pend_q & ~rd_src_i_q;
    i_rdata_o  = 16'h0000;
    d_rdata_o  = 16'h0000;
    if (i_rvalid_o) begin
      i_rdata_o = rdata_s;
    end else if (d_rvalid_o) begin
      d_rdata_o = rdata_s;
    end else begin
      i_rdata_o = 16'h0000;
    end
  end

endmodule

// File: tb/tb_risc16b_mem_arbiter.sv
// Self-checking bench for risc16b_mem_arbiter with a synchronous memory/I/O model
// and a read-return scoreboard.
module tb_risc16b_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_we;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [15:0] i_rdata, d_rdata;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        m_oe, io_oe;
  logic [1:0]  m_we, io_we;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata, io_rdata;

  logic [15:0] mem [0:1023];
  logic [15:0] io_regs [0:127];

  typedef struct packed {
    logic        src_i;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q[$];
  sb_t exp_e;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  risc16b_mem_arbiter #(.STARVE_LIMIT(4), .IO_PAGE(8'h7f)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .m_addr_o(m_addr), .m_oe_o(m_oe), .m_we_o(m_we), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata),
    .io_addr_o(io_addr), .io_oe_o(io_oe), .io_we_o(io_we), .io_wdata_o(io_wdata),
    .io_rdata_i(io_rdata)
  );

  // Synchronous memory and I/O models; contents are (re)loaded while reset is low.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[10'h080]  <= 16'h1234;
      mem[10'h008]  <= 16'hC0DE;
      mem[10'h100]  <= 16'h1122;
      mem[10'h020]  <= 16'h4040;
      io_regs[7'h01] <= 16'h0055;
      m_rdata  <= 16'hDEAD;
      io_rdata <= 16'h0BAD;
    end else begin
      if (m_we[0]) mem[m_addr[10:1]][15:8] <= m_wdata[15:8];
      if (m_we[1]) mem[m_addr[10:1]][7:0]  <= m_wdata[7:0];
      if (io_we[0]) io_regs[io_addr[7:1]][15:8] <= io_wdata[15:8];
      if (io_we[1]) io_regs[io_addr[7:1]][7:0]  <= io_wdata[7:0];
      m_rdata  <= m_oe  ? mem[m_addr[10:1]]      : 16'hDEAD;
      io_rdata <= io_oe ? io_regs[io_addr[7:1]] : 16'h0BAD;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_req = 1'b0; d_req = 1'b0; d_we = 2'b00;
    i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 16'h0100;
    d_req = 1'b1; d_addr = 16'h0200; d_we = 2'b11; d_wdata = 16'hFFFF;
    @(negedge clk);
    n_cmp++;
    if ({i_gnt, d_gnt, m_oe, io_oe, m_we, io_we, i_rvalid, d_rvalid} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b expected 0", {i_gnt, d_gnt, m_oe, io_oe, m_we, io_we, i_rvalid, d_rvalid});
    end
    n_cmp++;
    if ({i_rdata, d_rdata} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata});
    end
    @(posedge clk);
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_read;
    d_req = 1'b1; d_addr = 16'h0040; d_we = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1 || m_oe !== 1'b1) begin
      n_err++;
      $display("FAIL midread_grant: got gnt=%b oe=%b expected 1 1", d_gnt, m_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({i_gnt, d_gnt, m_oe, io_oe, m_we, io_we} !== 8'b0) begin
      n_err++;
      $display("FAIL midread_async_gate: got %b expected 0", {i_gnt, d_gnt, m_oe, io_oe, m_we, io_we});
    end
    d_req = 1'b0;
    tick();
    n_cmp++;
    if (d_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL midread_rvalid_in_reset: got %b expected 0", d_rvalid);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== 16'h0000) begin
        n_err++;
        $display("FAIL midread_after_release: got rv=%b data=%h expected 0 0000", d_rvalid, d_rdata);
      end
      tick();
    end
  endtask

  task automatic test_fetch;
    i_req = 1'b1; i_addr = 16'h0100;
    @(negedge clk);
    n_cmp++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || m_oe !== 1'b1 || m_addr !== 16'h0100 || io_oe !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_cmd: got gnt=%b oe=%b addr=%h expected 1 1 0100", i_gnt, m_oe, m_addr);
    end
    sb_q.push_back('{src_i: 1'b1, data: 16'h1234});
    tick();
    i_req = 1'b0;
    @(negedge clk);
    if (sb_q.size() != 0) begin
      exp_e = sb_q.pop_front();
      n_cmp++;
      if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== exp_e.data) begin
        n_err++;
        $display("FAIL fetch_rdata: got rv=%b/%b data=%h expected 1/0 %h", i_rvalid, d_rvalid, i_rdata, exp_e.data);
      end
    end
    tick();
  endtask

  task automatic test_fairness;
    logic exp_i;
    i_req = 1'b1; i_addr = 16'h0010;
    d_req = 1'b1; d_addr = 16'h0100; d_we = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        n_cmp++;
        if ((exp_e.src_i ? i_rvalid : d_rvalid) !== 1'b1 || (exp_e.src_i ? d_rvalid : i_rvalid) !== 1'b0 ||
            (exp_e.src_i ? i_rdata : d_rdata) !== exp_e.data) begin
          n_err++;
          $display("FAIL fair_rdata[%0d]: got rv_i=%b rv_d=%b i=%h d=%h expected src_i=%b data=%h",
                   k, i_rvalid, d_rvalid, i_rdata, d_rdata, exp_e.src_i, exp_e.data);
        end
      end
      exp_i = ((k % 5) == 4);
      n_cmp++;
      if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
        n_err++;
        $display("FAIL fair_grant[%0d]: got i=%b d=%b expected i=%b d=%b", k, i_gnt, d_gnt, exp_i, !exp_i);
      end
      sb_q.push_back(exp_i ? '{src_i: 1'b1, data: 16'hC0DE} : '{src_i: 1'b0, data: 16'h1234});
      tick();
    end
    idle_inputs();
    @(negedge clk);
    if (sb_q.size() != 0) begin
      exp_e = sb_q.pop_front();
      n_cmp++;
      if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== exp_e.data) begin
        n_err++;
        $display("FAIL fair_last_rdata: got rv=%b/%b data=%h expected 1/0 %h", i_rvalid, d_rvalid, i_rdata, exp_e.data);
      end
    end
    tick();
  endtask

  task automatic test_io_write;
    d_req = 1'b1; d_addr = 16'h7f00; d_we = 2'b11; d_wdata = 16'hA5A5;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1 || io_we !== 2'b11 || io_addr !== 8'h00 || io_wdata !== 16'hA5A5 ||
        m_we !== 2'b00 || m_oe !== 1'b0 || io_oe !== 1'b0) begin
      n_err++;
      $display("FAIL io_write_cmd: got gnt=%b io_we=%b io_addr=%h io_wdata=%h m_we=%b oe=%b%b expected 1 11 00 a5a5 00 00",
               d_gnt, io_we, io_addr, io_wdata, m_we, m_oe, io_oe);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL io_write_norvalid: got %b%b expected 00", i_rvalid, d_rvalid);
    end
    tick();
  endtask

  task automatic test_byte_write;
    d_req = 1'b1; d_addr = 16'h0200; d_we = 2'b01; d_wdata = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1 || m_we !== 2'b01 || io_we !== 2'b00 || m_addr !== 16'h0200) begin
      n_err++;
      $display("FAIL byte_write_cmd: got gnt=%b m_we=%b io_we=%b addr=%h expected 1 01 00 0200", d_gnt, m_we, io_we, m_addr);
    end
    tick();
    d_we = 2'b00; d_wdata = 16'h0000;
    @(negedge clk);
    n_cmp++;
    if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || m_oe !== 1'b1) begin
      n_err++;
      $display("FAIL byte_readback_cmd: got rv=%b gnt=%b oe=%b expected 0 1 1", d_rvalid, d_gnt, m_oe);
    end
    sb_q.push_back('{src_i: 1'b0, data: 16'hBE22});
    tick();
    idle_inputs();
    @(negedge clk);
    if (sb_q.size() != 0) begin
      exp_e = sb_q.pop_front();
      n_cmp++;
      if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== exp_e.data) begin
        n_err++;
        $display("FAIL byte_readback_data: got rv=%b data=%h expected 1 %h", d_rvalid, d_rdata, exp_e.data);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back;
    i_req = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    n_cmp++;
    if (i_gnt !== 1'b1 || m_oe !== 1'b1 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_i_grant: got gnt=%b oe=%b rv=%b%b expected 1 1 00", i_gnt, m_oe, i_rvalid, d_rvalid);
    end
    sb_q.push_back('{src_i: 1'b1, data: 16'hC0DE});
    tick();
    i_req = 1'b0;
    d_req = 1'b1; d_addr = 16'h7f02; d_we = 2'b00;
    @(negedge clk);
    if (sb_q.size() != 0) begin
      exp_e = sb_q.pop_front();
      n_cmp++;
      if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== exp_e.data) begin
        n_err++;
        $display("FAIL b2b_i_rdata: got rv=%b/%b data=%h expected 1/0 %h", i_rvalid, d_rvalid, i_rdata, exp_e.data);
      end
    end
    n_cmp++;
    if (d_gnt !== 1'b1 || io_oe !== 1'b1 || m_oe !== 1'b0 || io_addr !== 8'h02) begin
      n_err++;
      $display("FAIL b2b_d_io_cmd: got gnt=%b io_oe=%b m_oe=%b io_addr=%h expected 1 1 0 02", d_gnt, io_oe, m_oe, io_addr);
    end
    sb_q.push_back('{src_i: 1'b0, data: 16'h0055});
    tick();
    idle_inputs();
    @(negedge clk);
    if (sb_q.size() != 0) begin
      exp_e = sb_q.pop_front();
      n_cmp++;
      if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== exp_e.data || i_rdata !== 16'h0000) begin
        n_err++;
        $display("FAIL b2b_d_rdata: got rv=%b/%b d=%h i=%h expected 1/0 %h 0000", d_rvalid, i_rvalid, d_rdata, i_rdata, exp_e.data);
      end
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_idle: got rv=%b%b pending=%0d expected 00 0", i_rvalid, d_rvalid, sb_q.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_reset_mid_read();
    test_fetch();
    test_fairness();
    test_io_write();
    test_byte_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
